// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding imem handshake,
// buffers returned words through a one-entry skid, and pre-classifies each word for ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [3:0]  ir_type,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_REQ  = 2'b00;
  localparam logic [1:0] S_IDLE = 2'b01;
  localparam logic [1:0] S_DROP = 2'b10;

  localparam logic [3:0] LUI_IR      = 4'd0;
  localparam logic [3:0] AUIPC_IR    = 4'd1;
  localparam logic [3:0] JAL_IR      = 4'd2;
  localparam logic [3:0] JALR_IR     = 4'd3;
  localparam logic [3:0] BRANCH_IR   = 4'd4;
  localparam logic [3:0] LOAD_IR     = 4'd5;
  localparam logic [3:0] STORE_IR    = 4'd6;
  localparam logic [3:0] REG_IMM_IR  = 4'd7;
  localparam logic [3:0] REG_REG_IR  = 4'd8;
  localparam logic [3:0] SYS_CALL_IR = 4'd9;
  localparam logic [3:0] CSR_IR      = 4'd10;
  localparam logic [3:0] RSVD_IR     = 4'b1111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [3:0] classify(input logic [31:0] w);
    case (w[6:0])
      7'b0110111: return LUI_IR;
      7'b0010111: return AUIPC_IR;
      7'b1101111: return JAL_IR;
      7'b1100111: return JALR_IR;
      7'b1100011: return BRANCH_IR;
      7'b0000011: return LOAD_IR;
      7'b0100011: return STORE_IR;
      7'b0010011: return REG_IMM_IR;
      7'b0110011: return REG_REG_IR;
      7'b1110011: return (w[14:12] == 3'b000) ? SYS_CALL_IR : CSR_IR;
      default:    return RSVD_IR;
    endcase
  endfunction

  logic [1:0]  state;
  logic [31:0] fpc;
  logic [31:0] tgt;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_ir;

  logic        out_free;
  logic        drain;
  logic        fetch_ack;
  logic [31:0] rpc_word;

  // Handshake: imem_req/imem_addr stay stable from assertion until the cycle imem_ack is high;
  // a word is transferred exactly in a cycle with imem_req && imem_ack. ID consumes the output
  // register on a cycle with if_valid && !stall.
  assign imem_req  = !rst && (state != S_IDLE);
  assign imem_addr = fpc;
  assign dbg_state = state;

  assign out_free  = !if_valid || !stall;
  assign drain     = if_valid && !stall && skid_valid;
  assign fetch_ack = (state == S_REQ) && imem_ack;
  assign rpc_word  = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      fpc        <= RESET_PC;
      tgt        <= RESET_PC;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_ir    <= NOP;
      if_valid   <= 1'b0;
      pc         <= 32'h0;
      ir         <= NOP;
      ir_type    <= REG_IMM_IR;
    end else if (redirect) begin
      if_valid   <= 1'b0;
      ir         <= NOP;
      ir_type    <= REG_IMM_IR;
      skid_valid <= 1'b0;
      // An unacked request must still complete on the bus, so park the target until it does.
      if (state == S_IDLE || imem_ack) begin
        fpc   <= rpc_word;
        state <= S_REQ;
      end else begin
        tgt   <= rpc_word;
        state <= S_DROP;
      end
    end else begin
      if (drain) begin
        if_valid   <= 1'b1;
        pc         <= skid_pc;
        ir         <= skid_ir;
        ir_type    <= classify(skid_ir);
        skid_valid <= 1'b0;
      end else if (out_free) begin
        if (fetch_ack) begin
          if_valid <= 1'b1;
          pc       <= fpc;
          ir       <= imem_rdata;
          ir_type  <= classify(imem_rdata);
        end else begin
          if_valid <= 1'b0;
          ir       <= NOP;
          ir_type  <= REG_IMM_IR;
        end
      end

      if (fetch_ack && !out_free) begin
        skid_valid <= 1'b1;
        skid_pc    <= fpc;
        skid_ir    <= imem_rdata;
      end

      case (state)
        S_REQ: begin
          if (imem_ack) begin
            fpc <= fpc + 32'd4;
            if (!out_free) state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!skid_valid || drain) state <= S_REQ;
        end
        S_DROP: begin
          if (imem_ack) begin
            fpc   <= tgt;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
